// File: rtl/pipe_adder_if.sv
// pipe_adder_if -- handshake and data bundle for pipe_adder.
//
// Parameters:
//   WIDTH     operand / result width in bits (must match the adder's WIDTH)
//
// Signals:
//   in_valid  producer offers an operand pair
//   in_ready  adder accepts the offered pair this cycle
//   a, b      operands
//   sub       0: a+b, 1: a-b
//   out_valid result presented
//   out_ready consumer takes the result
//   sum       result
//   cout      carry out of the MSB (inverted borrow for subtract)
//   ovf       two's-complement signed overflow
//
// Modports:
//   master    the producer/consumer side (testbench or surrounding logic)
//   slave     the adder side
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder -- pipelined ripple-carry adder/subtractor with valid/ready flow.
//
// The WIDTH-bit add is split into STAGES slices of WIDTH/STAGES bits. Stage k
// adds slice k using the carry registered by stage k-1 (stage 0 uses sub as
// its carry-in, with B inverted for subtraction). A final output register
// presents the result, so a pair accepted at edge N is presented after edge
// N+STAGES. The whole pipeline advances together and freezes when a result
// is presented but not taken.
//
// Parameters:
//   WIDTH   operand/result width (default 16)
//   STAGES  pipeline stages, must divide WIDTH exactly (default 4)
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     pipe_adder_if.slave: in_valid/in_ready/a/b/sub in,
//           out_valid/out_ready/sum/cout/ovf out
//
// Build option:
//   PIPE_ADDER_SAT_EN  when defined, sum saturates to the most positive or
//                      most negative value on signed overflow; otherwise it
//                      wraps. cout and ovf are identical in both builds.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}});
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Global advance: everything moves unless a presented result is refused.
  logic advance;

  // Stage registers
  logic             valid_reg [STAGES];
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];   // already inverted for subtract
  logic [WIDTH-1:0] res_reg   [STAGES];
  logic             carry_reg [STAGES];
  logic             ovf_reg   [STAGES];

  // Per-stage inputs and next values
  logic             v_in      [STAGES];
  logic [WIDTH-1:0] a_in      [STAGES];
  logic [WIDTH-1:0] b_in      [STAGES];
  logic [WIDTH-1:0] res_in    [STAGES];
  logic             c_in      [STAGES];
  logic [SW:0]      slice_sum [STAGES];
  logic [WIDTH-1:0] res_next  [STAGES];
  logic             ovf_next  [STAGES];

  logic [WIDTH-1:0] res_final;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign v_in[gi]   = bus.in_valid;
        assign a_in[gi]   = bus.a;
        assign b_in[gi]   = bus.b ^ {WIDTH{bus.sub}};
        assign res_in[gi] = '0;
        assign c_in[gi]   = bus.sub;
      end else begin : g_body
        assign v_in[gi]   = valid_reg[gi-1];
        assign a_in[gi]   = a_reg[gi-1];
        assign b_in[gi]   = b_reg[gi-1];
        assign res_in[gi] = res_reg[gi-1];
        assign c_in[gi]   = carry_reg[gi-1];
      end

      assign slice_sum[gi] = {1'b0, a_in[gi][gi*SW +: SW]}
                           + {1'b0, b_in[gi][gi*SW +: SW]}
                           + (SW+1)'(c_in[gi]);

      // Drop this stage's slice into the partially built result.
      assign res_next[gi] = (res_in[gi] & ~(SLICE_MASK << (gi*SW)))
                          | (WIDTH'(slice_sum[gi][SW-1:0]) << (gi*SW));

      // Carry into the slice MSB is a^b^sum at that bit; XOR with the carry
      // out gives signed overflow. Only the last stage's value is used.
      assign ovf_next[gi] = slice_sum[gi][SW]
                          ^ a_in[gi][gi*SW + SW - 1]
                          ^ b_in[gi][gi*SW + SW - 1]
                          ^ slice_sum[gi][SW-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        res_reg[k]   <= '0;
        carry_reg[k] <= 1'b0;
        ovf_reg[k]   <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= v_in[k];
        a_reg[k]     <= a_in[k];
        b_reg[k]     <= b_in[k];
        res_reg[k]   <= res_next[k];
        carry_reg[k] <= slice_sum[k][SW];
        ovf_reg[k]   <= ovf_next[k];
      end
    end
  end

  always_comb begin
    res_final = res_reg[LAST];
`ifdef PIPE_ADDER_SAT_EN
    // With overflow the wrapped sign is the opposite of the true sign.
    if (ovf_reg[LAST]) begin
      res_final = res_reg[LAST][WIDTH-1] ? SAT_MAX : SAT_MIN;
    end
`else
    res_final = res_reg[LAST];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= valid_reg[LAST];
      bus.sum       <= res_final;
      bus.cout      <= carry_reg[LAST];
      bus.ovf       <= ovf_reg[LAST];
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder -- directed self-checking bench for pipe_adder (WIDTH=16,
// STAGES=4). Expected values are hand-computed; the saturating build is
// selected with PIPE_ADDER_SAT_EN.
module tb_pipe_adder;

`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(16)) bus ();

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One isolated transaction: checks acceptance, the out_valid pattern over
  // edges 1..5 after acceptance (only edge 4 high), and the result fields.
  task automatic send_one(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic sub,
                          input logic [15:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
    logic [4:0]  seen;
    logic [15:0] s;
    logic        c;
    logic        o;
    seen = '0;
    s = '0;
    c = 1'b0;
    o = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.sub       = sub;
    bus.out_ready = 1'b1;
    #1;
    check_val({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      seen[k-1] = bus.out_valid;
      if (k == 4) begin
        s = bus.sum;
        c = bus.cout;
        o = bus.ovf;
      end
    end
    check_val({tag, ".latency"}, 32'(seen), 32'h08);
    check_val({tag, ".sum"}, 32'(s), 32'(exp_sum));
    check_val({tag, ".cout"}, 32'(c), 32'(exp_cout));
    check_val({tag, ".ovf"}, 32'(o), 32'(exp_ovf));
    $display("txn %s: a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d",
             tag, a, b, sub, s, c, o);
  endtask

  logic [15:0] st_a   [8];
  logic [15:0] st_b   [8];
  logic        st_sub [8];
  logic [15:0] st_exp [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int n_got;
    int stall_seen;
    int stale;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, with clock running and out_ready low.
    repeat (3) @(negedge clk);
    #1;
    check_val("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst.sum", 32'(bus.sum), 32'd0);
    check_val("rst.cout", 32'(bus.cout), 32'd0);
    check_val("rst.ovf", 32'(bus.ovf), 32'd0);
    check_val("rst.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
    $display("txn reset: released");

    // Isolated transactions.
    send_one("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    send_one("add_ovf_pos", 16'h7FFF, 16'h0001, 1'b0,
             SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    send_one("sub_neg", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send_one("sub_ovf_neg", 16'h8000, 16'h0001, 1'b1,
             SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
    send_one("add_wrap_cout", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("sub_pos", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    send_one("add_ovf_neg", 16'h8000, 16'h8000, 1'b0,
             SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);

    // Back-to-back stream with a 3-cycle consumer stall.
    st_a   = '{16'h0001, 16'h00FF, 16'h0F0F, 16'h1000,
               16'hABCD, 16'h0010, 16'h3000, 16'hFFFF};
    st_b   = '{16'h0001, 16'h0001, 16'h0101, 16'h0001,
               16'h1111, 16'h0020, 16'h4000, 16'hFFFF};
    st_sub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    st_exp = '{16'h0002, 16'h0100, 16'h1010, 16'h0FFF,
               16'hBCDE, 16'hFFF0, 16'h7000, 16'hFFFE};
    idx = 0;
    n_got = 0;
    stall_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      if (idx < 8) begin
        bus.in_valid = 1'b1;
        bus.a        = st_a[idx];
        bus.b        = st_b[idx];
        bus.sub      = st_sub[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stall_seen++;
        check_val("stall.in_ready", 32'(bus.in_ready), 32'd0);
        if (n_got < 8) check_val("stall.hold_sum", 32'(bus.sum), 32'(st_exp[n_got]));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (n_got < 8) begin
          check_val($sformatf("stream[%0d]", n_got), 32'(bus.sum), 32'(st_exp[n_got]));
          $display("txn stream[%0d]: sum=%h", n_got, bus.sum);
        end
        n_got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid = 1'b0;
    check_val("stream.accepted", 32'(idx), 32'd8);
    check_val("stream.results", 32'(n_got), 32'd8);
    check_val("stream.stall_cycles", 32'(stall_seen), 32'd3);

    // Reset with operations in flight and a result on the output.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 16'(i + 1);
      bus.b         = 16'h0000;
      bus.sub       = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_val("midrst.pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst.sum", 32'(bus.sum), 32'd0);
    check_val("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn midrst: reset pulsed with work in flight");
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check_val("midrst.stale_results", 32'(stale), 32'd0);
    send_one("post_midrst", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL take parameter STAGES, default 4, giving the number of pipeline stages; legal values divide WIDTH exactly, with 1 <= STAGES <= WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, signalling that an operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, signalling that the block accepts the offered pair this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 computes A+B; 1 computes A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit, signalling that a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit, signalling that the consumer takes the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits, the result.
REQ-013 The block SHALL have port cout, output, 1 bit, the carry out of the MSB (the inverted borrow when sub=1).
REQ-014 The block SHALL have port ovf, output, 1 bit, the two's-complement signed overflow flag.

Function
REQ-015 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; the output handshake completes on a rising edge where out_valid=1 and out_ready=1.
REQ-016 Each stage SHALL ripple-add one slice of WIDTH/STAGES bits, using the registered carry from the previous stage; slice 0 uses carry-in = sub.
REQ-017 When sub=1, B SHALL be inverted bitwise before entering the adder.
REQ-018 Operand slices not yet consumed, and result slices already produced, SHALL be carried forward in pipeline registers together with a per-stage valid bit.
REQ-019 Latency SHALL be exactly STAGES cycles: a pair accepted at edge N appears with out_valid=1 after edge N+STAGES when no stall occurs.
REQ-020 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-021 The pipeline SHALL stall as a whole when out_valid=1 and out_ready=0; in_ready SHALL equal (NOT out_valid) OR out_ready, combinationally.
REQ-022 During a stall, all stage registers, valid bits and outputs SHALL hold their values unchanged.
REQ-023 Bubbles SHALL propagate; a stage whose valid bit is 0 SHALL never produce out_valid=1.
REQ-024 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, for both add and subtract.
REQ-025 Operations SHALL retire strictly in acceptance order, and no result SHALL be dropped or duplicated.
REQ-026 For STAGES=1, the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-027 While rst_n=0, all stage valid bits and out_valid SHALL be 0, and sum, cout and ovf SHALL be 0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; after release, the first out_valid SHALL correspond only to a pair accepted after release.
REQ-029 in_ready SHALL be 1 during reset and on the first cycle after it.

Configuration
REQ-030 With macro PIPE_ADDER_SAT_EN defined, sum SHALL saturate on ovf=1: to 0 followed by all ones (maximum positive value) when the true result is positive, and to 1 followed by all zeros (minimum negative value) when it is negative; cout and ovf are unchanged.
REQ-031 Without PIPE_ADDER_SAT_EN defined, sum SHALL wrap modulo 2^WIDTH, and ovf SHALL still be reported.

Verification (WIDTH=16, STAGES=4)
REQ-032 Accept a=0x1234, b=0x0FFF, sub=0 at edge 0, with out_ready=1 -> sum=0x2233, cout=0, ovf=0, out_valid=1 after edge 4 for exactly one cycle.
REQ-033 Apply a=0x7FFF, b=0x0001, sub=0 -> ovf=1, cout=0; sum=0x8000 without the macro, sum=0x7FFF with PIPE_ADDER_SAT_EN.
REQ-034 Apply a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0; then a=0x8000, b=0x0001, sub=1 -> ovf=1, sum=0x7FFF (wrap) or 0x8000 (saturated).
REQ-035 Stream 8 back-to-back pairs with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during the stall, and all 8 results arrive in order with none lost or repeated.
REQ-036 Assert rst_n=0 for 1 cycle while 3 operations are in flight -> out_valid=0 immediately, no stale result appears afterwards, and a new pair returns exactly 4 cycles after acceptance.
